int_to_int_seq: RTL and testbench
=================================

Name: int_to_int_seq

Overview:
- Sequential front end that streams 32-bit words through one combinational int_to_int converter instance, which sits beside this block at the same hierarchy level.
- Drives the converter's instruction side and captures its result.
- Unpacks 16→32 jobs: one input word becomes two issues.
- Packs 32→16 jobs: two results become one output word.
- Presents results on a valid/ready output stream; sits between the vector load path and the writeback buffer.

Parameters:
CNT_W, 16, width of the in/out word status counters (wrap modulo 2^CNT_W).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cfg_src_prec  input  1  1=32-bit source, 0=16-bit; latched on the first beat of a packet
cfg_dst_prec  input  1  1=32-bit dest, 0=16-bit; latched on the first beat of a packet
cfg_src_signed  input  1  source signedness; latched on the first beat of a packet
cfg_dst_signed  input  1  dest signedness; latched on the first beat of a packet
in_vld  input  1  input word valid
in_rdy  output  1  input word accepted when in_vld&in_rdy
in_data  input  32  input word
in_last  input  1  last word of packet
out_vld  output  1  output word valid
out_rdy  input  1  downstream accepts when out_vld&out_rdy
out_data  output  32  converted word
out_last  output  1  last output word of packet
cv_instr_vld  output  1  to converter instr_vld
cv_src_prec  output  1  to converter
cv_dst_prec  output  1  to converter
cv_src_signed  output  1  to converter
cv_dst_signed  output  1  to converter
cv_src_pos  output  1  to converter
cv_dst_pos  output  1  to converter
cv_in_reg  output  32  to converter in_reg
cv_out_reg  input  32  from converter out_reg (combinational, same cycle)
cv_result_vld  input  1  from converter result_vld
cnt_in  output  CNT_W  accepted input words since reset
cnt_out  output  CNT_W  output words accepted downstream since reset
err  output  1  sticky: an issue cycle saw cv_result_vld=0

Behaviour:
- Reset values: in_rdy=0 during reset, out_vld=0, out_data=0, out_last=0, all cv_* = 0, cnt_in=cnt_out=0, err=0, state=IDLE, pack_half=0, pack_reg=0.
- Slot free (`slot_free`) = !out_vld | out_rdy. Any issue requires slot_free. cv_instr_vld=1 only in issue cycles; otherwise cv_* are held at 0.
- cfg latched on the first accepted beat of each packet and used for the whole packet. It is re-sampled on the beat after an in_last acceptance.
- FSM states: IDLE and HI.
- IDLE: in_rdy = slot_free. On acceptance, issue with cv_in_reg=in_data and cv_src_pos=cv_dst_pos=0, except for 32→16 (see below).
  - 32→32 or 16→16: one issue. The output register loads cv_out_reg next edge; out_last=in_last.
  - 32→16: cv_dst_pos=pack_half. The result half is cv_out_reg[15:0] if pack_half=0, else [31:16].
    - pack_half=0 and !in_last: store in pack_reg[15:0], set pack_half=1, no output.
    - pack_half=1: output {half, pack_reg[15:0]}, pack_half←0.
    - pack_half=0 and in_last: output {16'h0, half} immediately, out_last=1.
  - 16→32: issue src_pos=0 and output the result with out_last=0. Capture in_data in hold_reg and go to HI.
- HI: in_rdy=0. When slot_free, issue with cv_in_reg=hold_reg and src_pos=1. Output the result with out_last = the latched in_last, then return to IDLE.
- Latency: accepted beat at edge N gives out_vld at N+1. The 16→32 second word appears at N+2 if out_rdy held high; it is delayed one cycle per stalled cycle.
- Backpressure: out_vld&!out_rdy holds out_data/out_last stable and suppresses all issues and acceptance. State, pack_reg and hold_reg are preserved.
- Simultaneous drain+load in the same cycle is allowed (full throughput 1 word/cycle for 32→32 and 16→16).
- cnt_in increments on in_vld&in_rdy; cnt_out on out_vld&out_rdy; both wrap to 0.
- err sets on any cv_instr_vld=1 cycle with cv_result_vld=0; cleared only by reset.
- Async reset mid-packet discards pack_reg, hold_reg and any pending output word. After reset the next beat starts a new packet.

Test Plan:
- 32→32 s32→u32: beats 0x0000007F, 0xFFFFFF80 (last), out_rdy=1 → out 0x0000007F then 0x00000000 (out_last=1), back-to-back cycles, cnt_in=cnt_out=2.
- 32→16 s32→s16 packing: beats 0x00008000, 0xFFFF7FFF (last) → single output 0x80007FFF, out_last=1; cv_dst_pos 0 then 1.
- 32→16 odd count: beats 0x00000005, 0x00000006, 0x00000007 (last), u32→u16 → 0x00060005, then 0x00000007 with out_last=1.
- 16→32 s16→s32: beat 0x80007FFF (last) → 0x00007FFF (out_last=0) then 0xFFFF8000 (out_last=1); in_rdy=0 during HI.
- Backpressure: 16→16 stream of 4 words with out_rdy low 3 cycles after first output → out_data stable while stalled, no cv_instr_vld, all 4 outputs in order, no loss or duplication.
- Reset mid-32→16 packet after one beat (pack_half=1): rst_n low 1 cycle → out_vld=0, cnt=0. A new packet 0x00000001 (last) outputs 0x00000001; a forced cv_result_vld=0 during an issue sets err.

Source files
------------

// File: rtl/int_to_int_seq.sv
// Sequencer around a combinational int_to_int converter: unpacks 16->32 jobs into two
// issues, packs 32->16 results two-per-word, and drives a valid/ready output stream.
module int_to_int_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_src_prec,
    input  logic             cfg_dst_prec,
    input  logic             cfg_src_signed,
    input  logic             cfg_dst_signed,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             cv_instr_vld,
    output logic             cv_src_prec,
    output logic             cv_dst_prec,
    output logic             cv_src_signed,
    output logic             cv_dst_signed,
    output logic             cv_src_pos,
    output logic             cv_dst_pos,
    output logic [31:0]      cv_in_reg,
    input  logic [31:0]      cv_out_reg,
    input  logic             cv_result_vld,
    output logic [CNT_W-1:0] cnt_in,
    output logic [CNT_W-1:0] cnt_out,
    output logic             err
);

    typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

    state_t            state_reg, state_next;
    logic              pkt_start_reg;
    logic              cfg_src_prec_reg, cfg_dst_prec_reg;
    logic              cfg_src_signed_reg, cfg_dst_signed_reg;
    logic              pack_half_reg;
    logic [15:0]       pack_reg;
    logic [31:0]       hold_reg;
    logic              last_reg;
    logic              out_vld_reg, out_last_reg;
    logic [31:0]       out_data_reg;
    logic [CNT_W-1:0]  cnt_in_reg, cnt_out_reg;
    logic              err_reg;

    logic              slot_free, accept, use_live_cfg;
    logic              src_prec_eff, dst_prec_eff, src_signed_eff, dst_signed_eff;
    logic              mode_pack, mode_unpack;
    logic [15:0]       res_half;
    logic              issue, out_load, out_load_last;
    logic [31:0]       out_load_data;

    assign slot_free = !out_vld_reg || out_rdy;
    assign in_rdy    = rst_n && (state_reg == IDLE) && slot_free;
    assign accept    = in_vld && in_rdy;

    // The first beat of a packet sees the live cfg; later beats (and the HI half) the latched copy.
    assign use_live_cfg   = (state_reg == IDLE) && pkt_start_reg;
    assign src_prec_eff   = use_live_cfg ? cfg_src_prec   : cfg_src_prec_reg;
    assign dst_prec_eff   = use_live_cfg ? cfg_dst_prec   : cfg_dst_prec_reg;
    assign src_signed_eff = use_live_cfg ? cfg_src_signed : cfg_src_signed_reg;
    assign dst_signed_eff = use_live_cfg ? cfg_dst_signed : cfg_dst_signed_reg;
    assign mode_pack      = src_prec_eff && !dst_prec_eff;
    assign mode_unpack    = !src_prec_eff && dst_prec_eff;
    assign res_half       = pack_half_reg ? cv_out_reg[31:16] : cv_out_reg[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept && mode_unpack) state_next = HI;
            HI:   if (slot_free)             state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        issue         = 1'b0;
        out_load      = 1'b0;
        out_load_data = cv_out_reg;
        out_load_last = 1'b0;
        cv_in_reg     = 32'h0;
        cv_src_pos    = 1'b0;
        cv_dst_pos    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    issue     = 1'b1;
                    cv_in_reg = in_data;
                    if (mode_pack) begin
                        cv_dst_pos = pack_half_reg;
                        if (pack_half_reg) begin
                            out_load      = 1'b1;
                            out_load_data = {res_half, pack_reg};
                            out_load_last = in_last;
                        end else if (in_last) begin
                            out_load      = 1'b1;
                            out_load_data = {16'h0, res_half};
                            out_load_last = 1'b1;
                        end
                    end else begin
                        out_load      = 1'b1;
                        out_load_last = mode_unpack ? 1'b0 : in_last;
                    end
                end
            end
            HI: begin
                if (slot_free) begin
                    issue         = 1'b1;
                    cv_in_reg     = hold_reg;
                    cv_src_pos    = 1'b1;
                    out_load      = 1'b1;
                    out_load_last = last_reg;
                end
            end
            default: ;
        endcase
    end

    assign cv_instr_vld  = issue;
    assign cv_src_prec   = issue && src_prec_eff;
    assign cv_dst_prec   = issue && dst_prec_eff;
    assign cv_src_signed = issue && src_signed_eff;
    assign cv_dst_signed = issue && dst_signed_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_start_reg      <= 1'b1;
            cfg_src_prec_reg   <= 1'b0;
            cfg_dst_prec_reg   <= 1'b0;
            cfg_src_signed_reg <= 1'b0;
            cfg_dst_signed_reg <= 1'b0;
            pack_half_reg      <= 1'b0;
            pack_reg           <= 16'h0;
            hold_reg           <= 32'h0;
            last_reg           <= 1'b0;
            out_vld_reg        <= 1'b0;
            out_data_reg       <= 32'h0;
            out_last_reg       <= 1'b0;
            cnt_in_reg         <= '0;
            cnt_out_reg        <= '0;
            err_reg            <= 1'b0;
        end else begin
            if (accept) begin
                pkt_start_reg <= in_last;
                if (pkt_start_reg) begin
                    cfg_src_prec_reg   <= cfg_src_prec;
                    cfg_dst_prec_reg   <= cfg_dst_prec;
                    cfg_src_signed_reg <= cfg_src_signed;
                    cfg_dst_signed_reg <= cfg_dst_signed;
                end
                if (mode_pack) begin
                    if (pack_half_reg) begin
                        pack_half_reg <= 1'b0;
                    end else if (!in_last) begin
                        pack_reg      <= res_half;
                        pack_half_reg <= 1'b1;
                    end
                end
                if (mode_unpack) begin
                    hold_reg <= in_data;
                    last_reg <= in_last;
                end
            end
            if (out_load) begin
                out_vld_reg  <= 1'b1;
                out_data_reg <= out_load_data;
                out_last_reg <= out_load_last;
            end else if (out_rdy) begin
                out_vld_reg  <= 1'b0;
            end
            if (accept)
                cnt_in_reg <= cnt_in_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            if (out_vld_reg && out_rdy)
                cnt_out_reg <= cnt_out_reg + {{(CNT_W-1){1'b0}}, 1'b1};
            if (issue && !cv_result_vld)
                err_reg <= 1'b1;
        end
    end

    assign out_vld  = out_vld_reg;
    assign out_data = out_data_reg;
    assign out_last = out_last_reg;
    assign cnt_in   = cnt_in_reg;
    assign cnt_out  = cnt_out_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_int_to_int_seq.sv
// Directed bench for int_to_int_seq with a saturating int_to_int converter model alongside.
module tb_int_to_int_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_src_prec = 1'b0, cfg_dst_prec = 1'b0, cfg_src_signed = 1'b0, cfg_dst_signed = 1'b0;
    logic        in_vld = 1'b0, in_last = 1'b0, out_rdy = 1'b1;
    logic [31:0] in_data = 32'h0;
    logic        in_rdy, out_vld, out_last, cv_instr_vld;
    logic [31:0] out_data, cv_in_reg, cv_out_reg;
    logic        cv_src_prec, cv_dst_prec, cv_src_signed, cv_dst_signed, cv_src_pos, cv_dst_pos;
    logic        cv_result_vld, bad = 1'b0;
    logic [15:0] cnt_in, cnt_out;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [32:0] oq[$];
    int          ot[$];
    logic [1:0]  iq[$];

    always #5 clk = ~clk;

    int_to_int_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_src_prec(cfg_src_prec), .cfg_dst_prec(cfg_dst_prec),
        .cfg_src_signed(cfg_src_signed), .cfg_dst_signed(cfg_dst_signed),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .in_last(in_last),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .cv_instr_vld(cv_instr_vld), .cv_src_prec(cv_src_prec), .cv_dst_prec(cv_dst_prec),
        .cv_src_signed(cv_src_signed), .cv_dst_signed(cv_dst_signed),
        .cv_src_pos(cv_src_pos), .cv_dst_pos(cv_dst_pos), .cv_in_reg(cv_in_reg),
        .cv_out_reg(cv_out_reg), .cv_result_vld(cv_result_vld),
        .cnt_in(cnt_in), .cnt_out(cnt_out), .err(err)
    );

    // Converter: pick source half, saturate into destination range, place into dest half.
    function automatic logic [31:0] conv(input logic [31:0] x, input logic sp, input logic dp,
                                         input logic ss, input logic ds, input logic spos, input logic dpos);
        longint v, lo, hi;
        logic [15:0] h;
        logic [63:0] r;
        if (sp) v = ss ? longint'({{32{x[31]}}, x}) : longint'({32'h0, x});
        else begin
            h = spos ? x[31:16] : x[15:0];
            v = ss ? longint'({{48{h[15]}}, h}) : longint'({48'h0, h});
        end
        if (dp) begin lo = ds ? -64'sd2147483648 : 0; hi = ds ? 64'sd2147483647 : 64'sd4294967295; end
        else    begin lo = ds ? -64'sd32768 : 0;      hi = ds ? 64'sd32767 : 64'sd65535; end
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        r = v;
        if (dp) return r[31:0];
        return dpos ? {r[15:0], 16'h0} : {16'h0, r[15:0]};
    endfunction

    assign cv_out_reg    = conv(cv_in_reg, cv_src_prec, cv_dst_prec, cv_src_signed, cv_dst_signed,
                                cv_src_pos, cv_dst_pos);
    assign cv_result_vld = !bad;

    always @(posedge clk) begin
        cyc++;
        if (rst_n && out_vld && out_rdy) begin
            oq.push_back({out_last, out_data});
            ot.push_back(cyc);
        end
        if (cv_instr_vld) iq.push_back({cv_src_pos, cv_dst_pos});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic sp, input logic dp, input logic ss, input logic ds);
        @(negedge clk);
        cfg_src_prec = sp; cfg_dst_prec = dp; cfg_src_signed = ss; cfg_dst_signed = ds;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        logic acc = 1'b0;
        int   budget = 0;
        @(negedge clk);
        in_vld = 1'b1; in_data = d; in_last = l;
        while (!acc && budget < 50) begin
            #1 acc = in_rdy;
            @(posedge clk);
            if (!acc) @(negedge clk);
            budget++;
        end
        chk("send_accept", {63'h0, acc}, 64'h1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_vld = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        oq.delete(); ot.delete(); iq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with out_rdy high so only reset can hold in_rdy low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy",  {63'h0, in_rdy}, 64'h0);
        chk("rst_out_vld", {63'h0, out_vld}, 64'h0);
        chk("rst_out",     {31'h0, out_last, out_data}, 64'h0);
        chk("rst_cv",      {63'h0, cv_instr_vld}, 64'h0);
        chk("rst_cv_in",   {32'h0, cv_in_reg}, 64'h0);
        chk("rst_cnt",     {32'h0, cnt_in, cnt_out}, 64'h0);
        chk("rst_err",     {63'h0, err}, 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // 32->32 s32->u32, back to back.
        set_cfg(1, 1, 1, 0);
        clear_q();
        send(32'h0000007F, 0);
        send(32'hFFFFFF80, 1);
        idle(3);
        chk("t1_n",    oq.size(), 2);
        chk("t1_o0",   oq[0], {1'b0, 32'h0000007F});
        chk("t1_o1",   oq[1], {1'b1, 32'h00000000});
        chk("t1_b2b",  ot[1] - ot[0], 1);
        chk("t1_cnt",  {32'h0, cnt_in, cnt_out}, {32'h0, 16'd2, 16'd2});

        // 32->16 s32->s16 packing.
        set_cfg(1, 0, 1, 1);
        clear_q();
        send(32'h00008000, 0);
        send(32'hFFFF7FFF, 1);
        idle(3);
        chk("t2_n",    oq.size(), 1);
        chk("t2_o0",   oq[0], {1'b1, 32'h80007FFF});
        chk("t2_ni",   iq.size(), 2);
        chk("t2_pos0", iq[0], 2'b00);
        chk("t2_pos1", iq[1], 2'b01);

        // 32->16 u32->u16, odd beat count.
        set_cfg(1, 0, 0, 0);
        clear_q();
        send(32'h00000005, 0);
        send(32'h00000006, 0);
        send(32'h00000007, 1);
        idle(3);
        chk("t3_n",    oq.size(), 2);
        chk("t3_o0",   oq[0], {1'b0, 32'h00060005});
        chk("t3_o1",   oq[1], {1'b1, 32'h00000007});

        // 16->32 s16->s32 unpack.
        set_cfg(0, 1, 1, 1);
        clear_q();
        send(32'h80007FFF, 1);
        @(negedge clk);
        in_vld = 1'b0; in_last = 1'b0;
        #1 chk("t4_hi_rdy", {63'h0, in_rdy}, 64'h0);
        repeat (3) @(negedge clk);
        chk("t4_n",    oq.size(), 2);
        chk("t4_o0",   oq[0], {1'b0, 32'h00007FFF});
        chk("t4_o1",   oq[1], {1'b1, 32'hFFFF8000});
        chk("t4_b2b",  ot[1] - ot[0], 1);
        chk("t4_pos1", iq[1], 2'b10);

        // 16->16 stream with a 3-cycle downstream stall after the first output.
        set_cfg(0, 0, 0, 0);
        clear_q();
        send(32'h00000001, 0);
        @(negedge clk);
        out_rdy = 1'b0; in_data = 32'h00000002; in_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_stall_data", {31'h0, out_vld, out_data}, {31'h0, 1'b1, 32'h00000001});
            chk("t5_stall_rdy",  {62'h0, in_rdy, cv_instr_vld}, 64'h0);
            @(posedge clk);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        #1 chk("t5_resume_rdy", {63'h0, in_rdy}, 64'h1);
        @(posedge clk);
        send(32'h00000003, 0);
        send(32'h00000004, 1);
        idle(3);
        chk("t5_n",    oq.size(), 4);
        chk("t5_o0",   oq[0], {1'b0, 32'h00000001});
        chk("t5_o1",   oq[1], {1'b0, 32'h00000002});
        chk("t5_o2",   oq[2], {1'b0, 32'h00000003});
        chk("t5_o3",   oq[3], {1'b1, 32'h00000004});
        chk("t5_cnt",  {32'h0, cnt_in, cnt_out}, {32'h0, 16'd12, 16'd11});

        // Reset in the middle of a 32->16 packet, then a fresh packet and a forced converter error.
        set_cfg(1, 0, 0, 0);
        clear_q();
        send(32'h00000011, 0);
        idle(1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out", {63'h0, out_vld}, 64'h0);
        chk("t6_rst_cnt", {32'h0, cnt_in, cnt_out}, 64'h0);
        chk("t6_rst_rdy", {63'h0, in_rdy}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        send(32'h00000001, 1);
        idle(3);
        chk("t6_n",    oq.size(), 1);
        chk("t6_o0",   oq[0], {1'b1, 32'h00000001});
        chk("t6_err0", {63'h0, err}, 64'h0);
        @(negedge clk) bad = 1'b1;
        send(32'h00000002, 1);
        @(negedge clk);
        bad = 1'b0; in_vld = 1'b0; in_last = 1'b0;
        #1;
        chk("t6_err1", {63'h0, err}, 64'h1);
        chk("t6_cnt",  {48'h0, cnt_in}, 64'd2);
        idle(2);
        chk("t6_err_sticky", {63'h0, err}, 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
